// File: rtl/regfile_writeback.sv
// Write-back stage for the register file's single write port. ALU results and
// buffered variable-latency load results share AD3/WE3/WD3; a busy scoreboard tracks in-flight loads.
module regfile_writeback #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [ADDRESS_WIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  output logic                          alu_stall,
  input  logic                          ld_issue,
  input  logic [ADDRESS_WIDTH-1:0]      ld_issue_rd,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [ADDRESS_WIDTH-1:0]      ld_rd,
  input  logic [DATA_WIDTH-1:0]         ld_data,
  output logic [ADDRESS_WIDTH-1:0]      AD3,
  output logic                          WE3,
  output logic [DATA_WIDTH-1:0]         WD3,
  output logic [2**ADDRESS_WIDTH-1:0]   busy
);
  localparam int NUM_REGS = 2**ADDRESS_WIDTH;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W    = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    data;
  } wb_req_t;

  wb_req_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [STV_W-1:0]    starve_cnt, starve_nxt;
  logic [NUM_REGS-1:0] busy_nxt;

  wb_req_t cand, ld_req;
  logic    ld_acc, fifo_nonempty, bypass_ok, cand_valid;
  logic    alu_win, ld_win, pop, push;

  always_comb begin
    ld_ready      = (count < CNT_W'(FIFO_DEPTH));
    ld_acc        = ld_valid && ld_ready;
    fifo_nonempty = (count != '0);
    ld_req.rd     = ld_rd;
    ld_req.data   = ld_data;
    // An incoming load may skip the FIFO only when nothing older is queued.
    bypass_ok     = !fifo_nonempty && ld_acc && (ld_rd != '0);
    cand_valid    = fifo_nonempty || bypass_ok;
    cand          = fifo_nonempty ? fifo_q[rd_ptr] : ld_req;
    alu_win       = !alu_stall && alu_valid && (alu_rd != '0);
    ld_win        = !alu_win && cand_valid;
    pop           = ld_win && fifo_nonempty;
    push          = ld_acc && (ld_rd != '0) && !(ld_win && !fifo_nonempty);
    count_nxt     = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (pop && !push) count_nxt = count - CNT_W'(1);
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || !fifo_nonempty)
      starve_nxt = '0;
    else if (starve_cnt != STV_W'(STARVE_LIMIT))
      starve_nxt = starve_cnt + STV_W'(1);
  end

  // Issue sets after commit clears so a re-issue to the same rd stays busy.
  always_comb begin
    busy_nxt = busy;
    if (ld_win)   busy_nxt[cand.rd]     = 1'b0;
    if (ld_issue) busy_nxt[ld_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= ld_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
      busy       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_nxt;
      starve_cnt <= starve_nxt;
      alu_stall  <= (starve_nxt == STV_W'(STARVE_LIMIT));
      busy       <= busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WE3 <= 1'b0;
      AD3 <= '0;
      WD3 <= '0;
    end else if (alu_win) begin
      WE3 <= 1'b1;
      AD3 <= alu_rd;
      WD3 <= alu_data;
    end else if (ld_win) begin
      WE3 <= 1'b1;
      AD3 <= cand.rd;
      WD3 <= cand.data;
    end else begin
      WE3 <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a vector table of single-cycle
// transactions plus hand sequences for reset, scoreboard and FIFO starvation.
module tb_regfile_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  AD3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] busy;

  int n_cmp = 0;
  int n_err = 0;

  regfile_writeback dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .AD3(AD3), .WE3(WE3), .WD3(WD3), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] adt;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ldt;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] w3;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1; alu_rd = rd; alu_data = d;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [31:0] d);
    ld_valid = 1; ld_rd = rd; ld_data = d;
  endtask

  task automatic chk_wr(input string name, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({name, ".WE3"}, {31'd0, WE3}, {31'd0, we});
    if (we) begin
      chk({name, ".AD3"}, {27'd0, AD3}, {27'd0, a});
      chk({name, ".WD3"}, WD3, d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with both sources presenting work.
    idle();
    rst = 1;
    drive_alu(5'd2, 32'h22);
    drive_ld(5'd10, 32'hAA);
    #3;
    chk("rst.WE3", {31'd0, WE3}, 32'd0);
    chk("rst.busy", busy, 32'd0);
    chk("rst.ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst.alu_stall", {31'd0, alu_stall}, 32'd0);
    #9 rst = 0;
    step();
    chk_wr("rst.first", 1, 5'd2, 32'h22);
    idle();
    step();
    chk_wr("rst.bufld", 1, 5'd10, 32'hAA);
    step();
    chk_wr("rst.idle", 0, 5'd0, 32'd0);

    // Single-cycle vector table; FIFO starts empty.
    vecs[0] = '{1, 5'd5,  32'h11,       0, 5'd0,  32'h0,    1, 5'd5,  32'h11};
    vecs[1] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd5,  32'h11};
    vecs[2] = '{1, 5'd0,  32'hFF,       1, 5'd3,  32'h5,    1, 5'd3,  32'h5};
    vecs[3] = '{0, 5'd0,  32'h0,        1, 5'd0,  32'h77,   0, 5'd3,  32'h5};
    vecs[4] = '{1, 5'd8,  32'h88,       1, 5'd0,  32'h99,   1, 5'd8,  32'h88};
    vecs[5] = '{1, 5'd4,  32'h44,       1, 5'd6,  32'h66,   1, 5'd4,  32'h44};
    vecs[6] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 5'd6,  32'h66};
    vecs[7] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd6,  32'h66};
    vecs[8] = '{1, 5'd31, 32'hFFFFFFFF, 0, 5'd0,  32'h0,    1, 5'd31, 32'hFFFFFFFF};
    vecs[9] = '{0, 5'd0,  32'h0,        1, 5'd1,  32'hDEAD, 1, 5'd1,  32'hDEAD};
    for (int i = 0; i < 10; i++) begin
      idle();
      alu_valid = vecs[i].av; alu_rd = vecs[i].ar; alu_data = vecs[i].adt;
      ld_valid  = vecs[i].lv; ld_rd  = vecs[i].lr; ld_data  = vecs[i].ldt;
      #1;
      chk($sformatf("vec%0d.ld_ready", i), {31'd0, ld_ready}, 32'd1);
      step();
      chk($sformatf("vec%0d.WE3", i), {31'd0, WE3}, {31'd0, vecs[i].we});
      chk($sformatf("vec%0d.AD3", i), {27'd0, AD3}, {27'd0, vecs[i].a3});
      chk($sformatf("vec%0d.WD3", i), WD3, vecs[i].w3);
    end
    idle();
    step();

    // Scoreboard: issue, commit clears at the same edge WE3 rises.
    ld_issue = 1; ld_issue_rd = 5'd7;
    step();
    chk("sb.set7", {31'd0, busy[7]}, 32'd1);
    idle();
    step();
    step();
    chk("sb.hold7", busy, 32'h0000_0080);
    drive_ld(5'd7, 32'hABCD);
    step();
    chk_wr("sb.commit7", 1, 5'd7, 32'hABCD);
    chk("sb.clr7", busy, 32'd0);
    idle();

    // Same-cycle issue and commit to rd 9: set wins.
    ld_issue = 1; ld_issue_rd = 5'd9;
    step();
    idle();
    drive_ld(5'd9, 32'h99);
    ld_issue = 1; ld_issue_rd = 5'd9;
    step();
    chk_wr("sb.same9", 1, 5'd9, 32'h99);
    chk("sb.setwins9", busy, 32'h0000_0200);
    idle();
    // ALU write to a busy register leaves it busy; x0 never becomes busy.
    drive_alu(5'd9, 32'h1234);
    ld_issue = 1; ld_issue_rd = 5'd0;
    step();
    chk_wr("sb.alu9", 1, 5'd9, 32'h1234);
    chk("sb.alu_keeps9", busy, 32'h0000_0200);
    idle();
    drive_ld(5'd9, 32'h999);
    step();
    chk("sb.clr9", busy, 32'd0);
    idle();
    step();

    // FIFO fill and starvation with ALU writing every cycle.
    drive_alu(5'd20, 32'h20);
    drive_ld(5'd14, 32'hA1);
    #1 chk("st.ready0", {31'd0, ld_ready}, 32'd1);
    step();
    chk_wr("st.alu20", 1, 5'd20, 32'h20);
    drive_alu(5'd21, 32'h21);
    drive_ld(5'd15, 32'hB2);
    #1 chk("st.ready1", {31'd0, ld_ready}, 32'd1);
    step();
    drive_alu(5'd22, 32'h22);
    drive_ld(5'd16, 32'hC3);
    #1 chk("st.full", {31'd0, ld_ready}, 32'd0);
    step();
    chk("st.nostall2", {31'd0, alu_stall}, 32'd0);
    drive_alu(5'd23, 32'h23);
    step();
    chk("st.nostall3", {31'd0, alu_stall}, 32'd0);
    drive_alu(5'd24, 32'h24);
    step();
    chk_wr("st.alu24", 1, 5'd24, 32'h24);
    chk("st.stall", {31'd0, alu_stall}, 32'd1);
    alu_valid = 0;
    #1 chk("st.full2", {31'd0, ld_ready}, 32'd0);
    step();
    chk_wr("st.popA", 1, 5'd14, 32'hA1);
    chk("st.stall_fall", {31'd0, alu_stall}, 32'd0);
    #1 chk("st.ready_after_pop", {31'd0, ld_ready}, 32'd1);
    step();
    chk_wr("st.popB", 1, 5'd15, 32'hB2);
    idle();
    step();
    chk_wr("st.popC", 1, 5'd16, 32'hC3);
    step();
    chk_wr("st.empty", 0, 5'd0, 32'd0);

    // Reset mid-operation drops buffered loads and busy flags.
    drive_alu(5'd4, 32'h40);
    drive_ld(5'd11, 32'hBB);
    ld_issue = 1; ld_issue_rd = 5'd13;
    step();
    chk_wr("mr.alu4", 1, 5'd4, 32'h40);
    chk("mr.busy13", busy, 32'h0000_2000);
    idle();
    #2 rst = 1;
    #1;
    chk("mr.WE3", {31'd0, WE3}, 32'd0);
    chk("mr.busy", busy, 32'd0);
    chk("mr.ld_ready", {31'd0, ld_ready}, 32'd1);
    #1 rst = 0;
    step();
    chk("mr.fifo_lost", {31'd0, WE3}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
